// File: rtl/fx3_packet_reader.sv
// fx3_packet_reader: initiator side of the FX3 GPIF packet handshake.
// Raises readData, consumes the fixed-length burst delivered while fx3isReading
// is high, counts good bursts, flags bad lengths and a silent responder.
// Optional data checking is built when the PATTERN_CHECK_EN macro is defined:
// the incoming words must form a continuous 16-bit incrementing sequence.
module fx3_packet_reader #(
    parameter int PACKET_WORDS   = 8192,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 4
) (
    input  logic        inclk,
    input  logic        nReset,
    input  logic        enable,
    input  logic        fx3isReading,
    input  logic [15:0] dataIn,
    output logic        readData,
    output logic        busy,
    output logic        packetDone,
    output logic [15:0] packetCount,
    output logic        lengthError,
    output logic        timeoutError,
    output logic        patternError
);

    localparam logic [15:0] PKT_LEN  = 16'(PACKET_WORDS);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_RECEIVE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        read_data_q, read_data_d;
    logic        busy_q, busy_d;
    logic        packet_done_q, packet_done_d;
    logic [15:0] packet_count_q, packet_count_d;
    logic        length_error_q, length_error_d;
    logic        timeout_error_q, timeout_error_d;
    logic        word_accept_s;

`ifdef PATTERN_CHECK_EN
    logic [15:0] expected_q, expected_d;
    logic        pattern_error_q, pattern_error_d;
`endif

    // Next-state and next-output logic for the handshake sequencer.
    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        timer_d         = timer_q;
        gap_cnt_d       = gap_cnt_q;
        read_data_d     = 1'b0;
        packet_done_d   = 1'b0;
        packet_count_d  = packet_count_q;
        length_error_d  = length_error_q;
        timeout_error_d = timeout_error_q;
        word_accept_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d     = ST_REQUEST;
                    read_data_d = 1'b1;
                    timer_d     = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (fx3isReading) begin
                    // The cycle that reveals the burst already carries word 1.
                    state_d       = ST_RECEIVE;
                    word_cnt_d    = 16'd1;
                    word_accept_s = 1'b1;
                end else if (timer_q == TO_LAST) begin
                    timeout_error_d = 1'b1;
                    state_d         = ST_GAP;
                    gap_cnt_d       = 16'd0;
                end else begin
                    read_data_d = 1'b1;
                    timer_d     = timer_q + 16'd1;
                end
            end
            ST_RECEIVE: begin
                if (fx3isReading) begin
                    word_accept_s = 1'b1;
                    if (word_cnt_q != 16'hFFFF) begin
                        word_cnt_d = word_cnt_q + 16'd1;
                    end else begin
                        word_cnt_d = word_cnt_q;
                    end
                end else begin
                    state_d       = ST_GAP;
                    gap_cnt_d     = 16'd0;
                    packet_done_d = 1'b1;
                    if (word_cnt_q == PKT_LEN) begin
                        packet_count_d = packet_count_q + 16'd1;
                    end else begin
                        length_error_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // Quiet period lets the sender clear its own word counter.
                if (gap_cnt_q == GAP_LAST) begin
                    if (enable) begin
                        state_d     = ST_REQUEST;
                        read_data_d = 1'b1;
                        timer_d     = 16'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

`ifdef PATTERN_CHECK_EN
    // Expected-word tracker: one increment per accepted word, continuous across bursts.
    always_comb begin
        expected_d      = expected_q;
        pattern_error_d = pattern_error_q;
        if (word_accept_s) begin
            if (dataIn != expected_q) begin
                pattern_error_d = 1'b1;
            end else begin
                pattern_error_d = pattern_error_q;
            end
            expected_d = expected_q + 16'd1;
        end else begin
            expected_d = expected_q;
        end
    end

    // Pattern checker registers, cleared only by reset.
    always_ff @(posedge inclk) begin
        if (!nReset) begin
            expected_q      <= 16'd0;
            pattern_error_q <= 1'b0;
        end else begin
            expected_q      <= expected_d;
            pattern_error_q <= pattern_error_d;
        end
    end

    assign patternError = pattern_error_q;
`else
    logic unused_data_s;
    assign unused_data_s = ^{dataIn, word_accept_s};
    assign patternError  = 1'b0;
`endif

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge inclk) begin
        if (!nReset) begin
            state_q         <= ST_IDLE;
            word_cnt_q      <= 16'd0;
            timer_q         <= 16'd0;
            gap_cnt_q       <= 16'd0;
            read_data_q     <= 1'b0;
            busy_q          <= 1'b0;
            packet_done_q   <= 1'b0;
            packet_count_q  <= 16'd0;
            length_error_q  <= 1'b0;
            timeout_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            timer_q         <= timer_d;
            gap_cnt_q       <= gap_cnt_d;
            read_data_q     <= read_data_d;
            busy_q          <= busy_d;
            packet_done_q   <= packet_done_d;
            packet_count_q  <= packet_count_d;
            length_error_q  <= length_error_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign readData     = read_data_q;
    assign busy         = busy_q;
    assign packetDone   = packet_done_q;
    assign packetCount  = packet_count_q;
    assign lengthError  = length_error_q;
    assign timeoutError = timeout_error_q;

endmodule

// File: tb/tb_fx3_packet_reader.sv
// Scoreboard bench for fx3_packet_reader: a sender model answers requests with
// directed bursts; expected results are queued at issue time and a monitor
// compares them when packetDone pulses or readData completes a pulse.
module tb_fx3_packet_reader;

    localparam int GAP = 4;

    logic        inclk = 1'b0;
    logic        nReset;
    logic        enable;
    logic        fx3isReading;
    logic [15:0] dataIn;
    logic        readData;
    logic        busy;
    logic        packetDone;
    logic [15:0] packetCount;
    logic        lengthError;
    logic        timeoutError;
    logic        patternError;

    fx3_packet_reader dut (
        .inclk        (inclk),
        .nReset       (nReset),
        .enable       (enable),
        .fx3isReading (fx3isReading),
        .dataIn       (dataIn),
        .readData     (readData),
        .busy         (busy),
        .packetDone   (packetDone),
        .packetCount  (packetCount),
        .lengthError  (lengthError),
        .timeoutError (timeoutError),
        .patternError (patternError)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        int count;
        int len_err;
        int to_err;
        int pat_err;
    } exp_t;

    exp_t sb_q[$];
    int   rd_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int          m_count = 0;
    int          m_len   = 0;
    int          m_to    = 0;
    int          m_pat   = 0;
    logic [15:0] pat     = 16'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter used for gap timing.
    always @(posedge inclk) cyc <= cyc + 1;

    int hi_len = 0;
    int done_cyc = 0;
    bit gap_pending = 1'b0;
    bit prev_rd = 1'b0;

    // Monitor: readData pulse lengths, re-request gap and packetDone results.
    always @(negedge inclk) begin
        exp_t e;
        int   el;
        if (readData === 1'b1) begin
            if (!prev_rd && gap_pending) begin
                chk("gap_len", cyc - done_cyc, GAP);
                gap_pending = 1'b0;
            end
            hi_len++;
        end else if (prev_rd) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", hi_len, 0);
            end else begin
                el = rd_q.pop_front();
                chk("rd_len", hi_len, el);
            end
            hi_len = 0;
        end
        if (packetDone === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("packetCount", int'(packetCount), e.count);
                chk("lengthError", int'(lengthError), e.len_err);
                chk("timeoutError", int'(timeoutError), e.to_err);
                chk("patternError", int'(patternError), e.pat_err);
                chk("busy_at_done", int'(busy), 1);
            end
            done_cyc    = cyc;
            gap_pending = 1'b1;
        end
        prev_rd = (readData === 1'b1);
    end

    task automatic wait_rd_high(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (readData) begin
                ok = 1'b1;
                break;
            end
            @(posedge inclk);
            #1;
        end
        if (!ok) chk("rd_wait_timeout", 0, 1);
    endtask

    // Sender model: answers one cycle after seeing readData, drives n words.
    task automatic serve(input int n, input int abort_at, input int corrupt_at);
        bit ok;
        wait_rd_high(ok);
        if (ok) begin
            @(posedge inclk);
            #1;
            for (int w = 1; w <= n; w++) begin
                fx3isReading = 1'b1;
                dataIn = (w == corrupt_at) ? 16'hFFFF : pat;
                if (w == corrupt_at) m_pat = 1;
                pat = pat + 16'd1;
                @(posedge inclk);
                #1;
                if (w == abort_at) return;
            end
            fx3isReading = 1'b0;
        end
    endtask

    task automatic issue_burst(input int n, input int corrupt_at);
        exp_t e;
        rd_q.push_back(2);
        if (n == 8192) m_count = (m_count + 1) % 65536;
        else m_len = 1;
        if (corrupt_at > 0) m_pat = 1;
        e.count = m_count; e.len_err = m_len; e.to_err = m_to; e.pat_err = m_pat;
        sb_q.push_back(e);
        serve(n, 0, corrupt_at);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_readData"}, int'(readData), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_packetDone"}, int'(packetDone), 0);
        chk({tag, "_packetCount"}, int'(packetCount), 0);
        chk({tag, "_lengthError"}, int'(lengthError), 0);
        chk({tag, "_timeoutError"}, int'(timeoutError), 0);
        chk({tag, "_patternError"}, int'(patternError), 0);
    endtask

    // Watchdog against a hung run.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        bit ok;
        int corrupt;
        nReset = 1'b0; enable = 1'b0; fx3isReading = 1'b0; dataIn = 16'd0;
        repeat (3) @(posedge inclk);
        #1;
        check_all_zero("reset");
        nReset = 1'b1;
        enable = 1'b1;

        // Three back-to-back good bursts.
        for (int b = 0; b < 3; b++) issue_burst(8192, 0);
        // Short burst, then a good one.
        issue_burst(8191, 0);
        issue_burst(8192, 0);

        // Silent sender: request held 64 cycles, then timeout.
        rd_q.push_back(64);
        wait_rd_high(ok);
        for (int i = 0; i < 100 && readData; i++) begin
            @(posedge inclk);
            #1;
        end
        chk("timeout_rd_low", int'(readData), 0);
        chk("timeoutError_set", int'(timeoutError), 1);
        chk("count_after_timeout", int'(packetCount), 4);
        m_to = 1;
        issue_burst(8192, 0);

        // Reset during word 4000 of a burst.
        rd_q.push_back(2);
        serve(8192, 4000, 0);
        nReset = 1'b0;
        fx3isReading = 1'b0;
        @(posedge inclk);
        #1;
        check_all_zero("midreset");
        nReset = 1'b1;
        m_count = 0; m_len = 0; m_to = 0; m_pat = 0; pat = 16'd0;

`ifdef PATTERN_CHECK_EN
        issue_burst(8192, 0);
        corrupt = 100;
`else
        corrupt = 0;
`endif
        issue_burst(8192, corrupt);
        enable = 1'b0;

        repeat (20) @(posedge inclk);
        #1;
        chk("final_idle_busy", int'(busy), 0);
        chk("sb_drained", sb_q.size(), 0);
        chk("rd_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
